alu_exec_ctrl: RTL

Sequencing stage directly upstream of the 32-bit combinational ALU. It accepts register-to-register commands over a valid/ready handshake and reads operands from an internal 32x32 register file. It drives alu_a/alu_b/alu_op, captures alu_out and writes the result back to the destination register. The ALU sits outside this block and is wired to its alu_* ports.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/regfile_2r1w.sv | 30 +++
 rtl/alu_exec_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and width constants shared by the ALU sequencer.
package alu_pkg;
    localparam int DW = 32;
    localparam int NREG = 32;
    localparam int AW = $clog2(NREG);

    localparam logic [4:0] OP_ZERO = 5'd0;
    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_AND = 5'd3;
    localparam logic [4:0] OP_OR = 5'd4;
    localparam logic [4:0] OP_XOR = 5'd5;
    localparam logic [4:0] OP_NOR = 5'd6;
    localparam logic [4:0] OP_LOADI = 5'd7;
    localparam logic [4:0] OP_LAST_ALU = OP_NOR;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB = 2'd2
    } state_t;
endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: register array with two operand reads, one debug read and one synchronous write; r0 reads 0.
module regfile_2r1w
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    input  logic [AW-1:0] ra3,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic [DW-1:0] rd3,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd
);
    logic [DW-1:0] mem [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we && wa != '0) begin
            mem[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
    assign rd2 = (ra2 == '0) ? '0 : mem[ra2];
    assign rd3 = (ra3 == '0) ? '0 : mem[ra3];
endmodule

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: IDLE/EXEC/WB sequencer feeding an external ALU and writing results back to the register file.
// Optional perf_retired/perf_err counters are enabled by defining ALU_EXEC_CTRL_PERF_EN.
module alu_exec_ctrl
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_op,
    input  logic [4:0]  cmd_rd,
    input  logic [4:0]  cmd_rs1,
    input  logic [4:0]  cmd_rs2,
    input  logic [31:0] cmd_imm,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [4:0]  alu_op,
    input  logic [31:0] alu_out,
    output logic        done_valid,
    output logic [4:0]  done_rd,
    output logic [31:0] done_data,
    output logic        err,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
`ifdef ALU_EXEC_CTRL_PERF_EN
    ,
    output logic [31:0] perf_retired,
    output logic [15:0] perf_err
`endif
);
    state_t state, next;
    logic [4:0] op_q;
    logic [AW-1:0] rd_q;
    logic [DW-1:0] imm_q, res_q, rs1_data, rs2_data;
    logic err_q;

    regfile_2r1w u_rf (
        .clk(clk),
        .rst(rst),
        .ra1(cmd_rs1),
        .ra2(cmd_rs2),
        .ra3(dbg_addr),
        .rd1(rs1_data),
        .rd2(rs2_data),
        .rd3(dbg_data),
        .we(state == WB && !err_q),
        .wa(rd_q),
        .wd(res_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= next;
    end

    always_comb begin
        next = state;
        cmd_ready = 1'b0;
        alu_op = OP_ZERO;
        done_valid = 1'b0;
        done_rd = '0;
        done_data = '0;
        err = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !rst;
                next = (cmd_valid && !rst) ? EXEC : IDLE;
            end
            EXEC: begin
                alu_op = op_q;
                next = WB;
            end
            WB: begin
                done_valid = 1'b1;
                done_rd = rd_q;
                done_data = res_q;
                err = err_q;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    // alu_a/alu_b only load on accept, so they hold their last values outside EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q <= '0;
            rd_q <= '0;
            imm_q <= '0;
            alu_a <= '0;
            alu_b <= '0;
            res_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                op_q <= cmd_op;
                rd_q <= cmd_rd;
                imm_q <= cmd_imm;
                alu_a <= rs1_data;
                alu_b <= rs2_data;
            end
            if (state == EXEC) begin
                res_q <= (op_q <= OP_LAST_ALU) ? alu_out : (op_q == OP_LOADI) ? imm_q : '0;
                err_q <= op_q > OP_LOADI;
            end
        end
    end

`ifdef ALU_EXEC_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_retired <= '0;
            perf_err <= '0;
        end else if (state == WB) begin
            perf_retired <= perf_retired + 32'd1;
            if (err_q) perf_err <= perf_err + 16'd1;
        end
    end
`endif
endmodule
